// File: rtl/cdce62002_spi_master.sv
// CDCE62002 SPI master: shifts 32-bit words LSB first on LE/CLK/MOSI, with an optional read-back frame over MISO.
// Frame is 65*CLK_DIV cycles with LE low, then GAP_CYCLES with LE high; cmd_ready only in IDLE, commands while busy are dropped.
module cdce62002_spi_master #(
  parameter int CLK_DIV    = 1,
  parameter int GAP_CYCLES = 4
) (
  input  logic        sysclk,
  input  logic        reset_INV,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_data,
  input  logic        cmd_read,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        spi_clk,
  output logic        spi_mosi,
  output logic        spi_cs_INV,
  input  logic        spi_miso
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WLEAD    = 3'd1,
    RLEAD    = 3'd2,
    SHIFT_HI = 3'd3,
    SHIFT_LO = 3'd4,
    GAP      = 3'd5
  } state_t;

  localparam logic [7:0] H_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] G_LAST = 8'(GAP_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  half_cnt;
  logic [7:0]  gap_cnt;
  logic [4:0]  bit_cnt;
  logic [31:0] tx_sh;
  logic [31:0] rx_sh;
  logic        is_read;
  logic        rd_frame;
  logic        half_done;
  logic        gap_done;
  logic        last_bit;
  logic        accept;

  assign half_done = (half_cnt == H_LAST);
  assign gap_done  = (gap_cnt == G_LAST);
  assign last_bit  = (bit_cnt == 5'd31);
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:         if (accept) state_nxt = WLEAD;
      WLEAD, RLEAD: if (half_done) state_nxt = SHIFT_HI;
      SHIFT_HI:     if (half_done) state_nxt = SHIFT_LO;
      SHIFT_LO:     if (half_done) state_nxt = last_bit ? GAP : SHIFT_HI;
      GAP:          if (gap_done) state_nxt = (is_read && !rd_frame) ? RLEAD : IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  // SPI pins are driven from dedicated flops, updated on the edge that enters each state.
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      state      <= IDLE;
      cmd_ready  <= 1'b0;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      spi_clk    <= 1'b0;
      spi_mosi   <= 1'b0;
      spi_cs_INV <= 1'b1;
      half_cnt   <= '0;
      gap_cnt    <= '0;
      bit_cnt    <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      is_read    <= 1'b0;
      rd_frame   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd_ready <= (state_nxt == IDLE);
      rsp_valid <= 1'b0;
      half_cnt  <= (state_nxt == state) ? half_cnt + 8'd1 : 8'd0;
      gap_cnt   <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
      case (state)
        IDLE: if (accept) begin
          tx_sh      <= {1'b0, cmd_data[31:1]};
          spi_mosi   <= cmd_data[0];
          spi_cs_INV <= 1'b0;
          is_read    <= cmd_read;
          rd_frame   <= 1'b0;
          bit_cnt    <= '0;
          rx_sh      <= '0;
          busy       <= 1'b1;
        end
        WLEAD, RLEAD: if (half_done) begin
          spi_clk <= 1'b1;
          if (rd_frame) rx_sh <= {spi_miso, rx_sh[31:1]};
        end
        SHIFT_HI: if (half_done) begin
          spi_clk <= 1'b0;
          if (last_bit) begin
            spi_mosi <= 1'b0;
          end else begin
            spi_mosi <= tx_sh[0];
            tx_sh    <= {1'b0, tx_sh[31:1]};
          end
        end
        SHIFT_LO: if (half_done) begin
          if (last_bit) begin
            spi_cs_INV <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
            spi_clk <= 1'b1;
            if (rd_frame) rx_sh <= {spi_miso, rx_sh[31:1]};
          end
        end
        GAP: if (gap_done) begin
          if (is_read && !rd_frame) begin
            // Read frame clocks out zeros while MISO is shifted in.
            rd_frame   <= 1'b1;
            spi_cs_INV <= 1'b0;
            spi_mosi   <= 1'b0;
            tx_sh      <= '0;
            bit_cnt    <= '0;
          end else begin
            rsp_valid <= 1'b1;
            rsp_data  <= is_read ? rx_sh : 32'd0;
            busy      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cdce62002_spi_master.md
Name: cdce62002_spi_master

Overview:
- Serial master that drives the CDCE62002 PLL configuration SPI (LE/CLK/MOSI) and optionally reads a register back over MISO.
- Sits directly downstream of the C66x power sequencer's PLL-configuration logic, which hands it 32-bit register words over a valid/ready handshake.
- Clocked from the internal UFM oscillator (3.3–5.5 MHz); replaces ad-hoc bit-banging of pll_spi_clk / pll_spi_mosi / pll_spi_cs_INV.

Parameters:
- CLK_DIV, default 1: SPI half-period in sysclk cycles (H). Legal range 1..255.
- GAP_CYCLES, default 4: minimum cycles with LE high between frames, and after a transaction. Legal range 1..255.

Ports:
- sysclk  input  1  system clock (UFM oscillator)
- reset_INV  input  1  asynchronous active-low reset
- cmd_valid  input  1  command word present
- cmd_ready  output  1  block can accept a command; high only in IDLE
- cmd_data  input  32  CDCE62002 word; address in bits [3:0]
- cmd_read  input  1  1 = after the write frame, run a read frame and capture MISO
- rsp_valid  output  1  one-cycle pulse when a transaction completes
- rsp_data  output  32  read-back word; 0 for write-only transactions
- busy  output  1  high from acceptance until rsp_valid
- spi_clk  output  1  CDCE62002 SPI_CLK
- spi_mosi  output  1  CDCE62002 SPI_MOSI
- spi_cs_INV  output  1  CDCE62002 SPI_LE, active low
- spi_miso  input  1  CDCE62002 SPI_MISO

Behaviour:

Reset:
- While reset_INV is low, asynchronously force the following: spi_cs_INV=1, spi_clk=0, spi_mosi=0, cmd_ready=0, busy=0, rsp_valid=0, rsp_data=0. All counters clear and state = IDLE.
- cmd_ready rises on the first sysclk edge after reset_INV deasserts.
- Reset mid-frame aborts the frame immediately. No partial response is produced.

Handshake:
- A command is accepted on the sysclk rising edge where cmd_valid & cmd_ready.
- cmd_data and cmd_read are captured on that edge.
- cmd_valid while busy is ignored; nothing is queued.
- rsp_valid pulses in the first IDLE cycle. cmd_ready is also high in that cycle, so a back-to-back command can be accepted on it.

Bit order and sampling:
- Words are shifted LSB first.
- The slave samples MOSI on the rising edge of spi_clk.
- MISO is sampled on the sysclk edge that raises spi_clk.

States:
- IDLE
  - Outputs: cs_INV=1, clk=0, mosi=0, cmd_ready=1.
  - On accept → WLEAD.
- WLEAD
  - Outputs: cs_INV=0, clk=0, mosi=bit0.
  - Hold H cycles → SHIFT_HI.
- SHIFT_HI
  - Output: clk=1.
  - Hold H cycles; in read frames, capture miso into bit k on entry → SHIFT_LO.
- SHIFT_LO
  - Output: clk=0.
  - On entry, mosi = bit k+1, or 0 after bit 31.
  - Hold H cycles.
  - If k<31: k++ → SHIFT_HI.
  - Otherwise → GAP, with cs_INV=1 on the first GAP cycle.
- GAP
  - Outputs: cs_INV=1, clk=0, mosi=0.
  - Hold GAP_CYCLES.
  - Then → RLEAD if this was the write frame of a read transaction; otherwise → IDLE with rsp_valid.
- RLEAD
  - Same as WLEAD but mosi=0; the read frame drives mosi=0 for all bits.
  - Then SHIFT_HI / SHIFT_LO / GAP as above, ending → IDLE with rsp_valid.

Frame timing and counters:
- spi_cs_INV is low for exactly 65·H cycles per frame, with exactly 32 spi_clk rising edges.
- Bit counter is 5 bits. Half-period counter is 8 bits. Gap counter is 8 bits.
- A frame-type flag distinguishes the write frame from the read frame.

rsp_data:
- Loaded when the transaction completes.
- Read transaction: the captured word.
- Write transaction: 0.
- Holds its value until the next completion or reset.

Glitch-free outputs:
- spi_clk, spi_mosi and spi_cs_INV are registered outputs (no combinational decode).
- spi_mosi changes only while spi_clk is low.

Test Plan:
- Write, CLK_DIV=1, GAP_CYCLES=4, cmd_data=0x8184_0320, cmd_read=0, accepted at cycle 0:
  - spi_cs_INV low cycles 1–65, with 32 clk rises at cycles 2,4,…,64.
  - Sampled MOSI reconstructs 0x8184_0320.
  - cs high cycles 66–69; rsp_valid in cycle 70 with rsp_data=0.
- Read, CLK_DIV=2, cmd_data=0x0000_000E, cmd_read=1, slave model returns 0xA5A5_1234 LSB first:
  - Two frames, each 130 cycles low, separated by 4 cycles high.
  - rsp_data=0xA5A5_1234; MOSI is 0 throughout the second frame.
- Back-to-back: cmd_valid held high with two different words:
  - The second word is accepted in the rsp_valid cycle of the first.
  - The gap between frames is exactly GAP_CYCLES+1 cycles high.
  - cmd_valid pulsed mid-frame is not accepted (cmd_ready=0).
- Reset mid-frame: reset_INV low at bit 10:
  - spi_cs_INV=1, spi_clk=0 and spi_mosi=0 asynchronously, before the next sysclk edge.
  - No rsp_valid.
  - After release, cmd_ready=1 and a fresh 0xFFFF_FFFF write completes normally.
- Boundary words 0x0000_0001 and 0x8000_0000:
  - MOSI high only at the first or last clk rise respectively.
  - MOSI never changes while spi_clk=1, checked by an assertion over all tests.
